// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, one synchronous write port and one
// synchronous read port on a single clock.
//   - per-byte write enables
//   - RD_LATENCY-deep read pipeline with a one-cycle valid strobe
//   - WR_FIRST selects new/merged (1) or old (0) data on a same-address collision
//   - after reset a sequencer zero-fills the whole array, one word per edge
// Optional feature: define DUAL_PORT_RAM_PARITY_EN to store one even-parity
// bit per byte lane, add the par_inject_i input and the rd_perr_o output.
module dual_port_ram #(
  parameter int  DATA_WIDTH = 16,
  parameter int  BYTE_WIDTH = 8,
  parameter int  ADDR_WIDTH = 6,
  parameter int  RD_LATENCY = 1,
  parameter int  WR_FIRST   = 1,
  localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_BYTES-1:0]  wr_be_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
`ifdef DUAL_PORT_RAM_PARITY_EN
  input  logic                  par_inject_i,
  output logic [NUM_BYTES-1:0]  rd_perr_o,
`endif
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  collision_o,
  output logic                  init_busy_o
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;

  logic wr_go, rd_go, rd_hit;
  logic [DATA_WIDTH-1:0] rd_old, rd_merged, rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NUM_BYTES-1:0] par_mem [DEPTH];
  logic [NUM_BYTES-1:0] wr_par, rd_par_old, rd_par_merged, rd_par, rd_perr_word;
  logic [NUM_BYTES-1:0] pipe_perr_q [RD_LATENCY];
`endif

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [RD_LATENCY-1:0] pipe_coll_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

  // State register and fill counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next state: walk the fill counter to DEPTH-1, then park in READY.
  // NOTE: every always_comb output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (state_q == ST_INIT) begin
      if (&fill_q) state_d = ST_READY;
      else         fill_d  = fill_q + 1'b1;
    end
  end

  assign init_busy_o = (state_q == ST_INIT);
  assign wr_go       = (state_q == ST_READY) && wr_en_i;
  assign rd_go       = (state_q == ST_READY) && rd_en_i;
  assign rd_hit      = wr_go && rd_go && (wr_addr_i == rd_addr_i);

  // Read word at acceptance; on a collision, optionally forward the merged write.
  always_comb begin
    rd_old    = mem[rd_addr_i];
    rd_merged = rd_old;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_be_i[b]) rd_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_word = (rd_hit && (WR_FIRST != 0)) ? rd_merged : rd_old;
  end

`ifdef DUAL_PORT_RAM_PARITY_EN
  // Lane parity for writes, forwarded parity on collisions, recheck on read.
  always_comb begin
    rd_par_old    = par_mem[rd_addr_i];
    rd_par_merged = rd_par_old;
    wr_par        = '0;
    rd_perr_word  = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      wr_par[b] = (^wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_inject_i;
      if (wr_be_i[b]) rd_par_merged[b] = wr_par[b];
    end
    rd_par = (rd_hit && (WR_FIRST != 0)) ? rd_par_merged : rd_par_old;
    for (int b = 0; b < NUM_BYTES; b++) begin
      rd_perr_word[b] = (^rd_word[b*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par[b];
    end
  end
`endif

  // Storage array: zero-fill during INIT, byte-lane writes once READY.
  // NOTE: the array has no reset; it is cleared by the fill sequencer so it
  // can map onto RAM macros, which have no reset on their contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[fill_q] <= '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
      par_mem[fill_q] <= '0;
`endif
    end else if (wr_go) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be_i[b]) begin
          mem[wr_addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef DUAL_PORT_RAM_PARITY_EN
          par_mem[wr_addr_i][b] <= wr_par[b];
`endif
        end
      end
    end
  end

  // Read pipeline: stage 0 captures at acceptance; payload moves only with
  // its valid bit so the last stage holds the previous word between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_coll_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
        pipe_perr_q[i] <= '0;
`endif
      end
    end else begin
      pipe_vld_q[0] <= rd_go;
      if (rd_go) begin
        pipe_data_q[0] <= rd_word;
        pipe_coll_q[0] <= rd_hit;
`ifdef DUAL_PORT_RAM_PARITY_EN
        pipe_perr_q[0] <= rd_perr_word;
`endif
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
          pipe_coll_q[i] <= pipe_coll_q[i-1];
`ifdef DUAL_PORT_RAM_PARITY_EN
          pipe_perr_q[i] <= pipe_perr_q[i-1];
`endif
        end
      end
    end
  end

  assign rd_data_o   = pipe_data_q[RD_LATENCY-1];
  assign rd_valid_o  = pipe_vld_q[RD_LATENCY-1];
  assign collision_o = pipe_vld_q[RD_LATENCY-1] & pipe_coll_q[RD_LATENCY-1];
`ifdef DUAL_PORT_RAM_PARITY_EN
  assign rd_perr_o   = pipe_vld_q[RD_LATENCY-1] ? pipe_perr_q[RD_LATENCY-1] : '0;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: three dual_port_ram instances share one stimulus stream
// (latency 2 / write-first, latency 1 / read-first, latency 4 / write-first)
// and are compared every cycle against a word-array reference model with a
// queue of expected read returns.
module tb_dual_port_ram;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
`ifdef DUAL_PORT_RAM_PARITY_EN
  logic        par_inj;
  logic [1:0]  perr [NI];
`endif

  logic [15:0] rdata [NI];
  logic        rvld  [NI];
  logic        coll  [NI];
  logic        busy  [NI];

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(2), .WR_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
`ifdef DUAL_PORT_RAM_PARITY_EN
    .par_inject_i(par_inj), .rd_perr_o(perr[0]),
`endif
    .rd_data_o(rdata[0]), .rd_valid_o(rvld[0]), .collision_o(coll[0]), .init_busy_o(busy[0]));

  dual_port_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(1), .WR_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
`ifdef DUAL_PORT_RAM_PARITY_EN
    .par_inject_i(par_inj), .rd_perr_o(perr[1]),
`endif
    .rd_data_o(rdata[1]), .rd_valid_o(rvld[1]), .collision_o(coll[1]), .init_busy_o(busy[1]));

  dual_port_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(4), .WR_FIRST(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
`ifdef DUAL_PORT_RAM_PARITY_EN
    .par_inject_i(par_inj), .rd_perr_o(perr[2]),
`endif
    .rd_data_o(rdata[2]), .rd_valid_o(rvld[2]), .collision_o(coll[2]), .init_busy_o(busy[2]));

  // Reference model state.
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
    logic        coll;
    logic [1:0]  perr;
  } exp_t;

  int          lat [NI] = '{2, 1, 4};
  bit          wf  [NI] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mdl_mem [DEPTH];
  logic [1:0]  mdl_inj [DEPTH];   // lanes whose stored parity was inverted
  logic [15:0] last_data [NI];
  exp_t        expq [$];
  int          init_left;
  int          edge_idx;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_idx);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NI; k++) begin
      int   idx;
      idx = -1;
      for (int i = 0; i < expq.size(); i++)
        if (expq[i].inst == k && expq[i].due == edge_idx) idx = i;
      check($sformatf("busy%0d", k), 32'(busy[k]), 32'(init_left > 0));
      check($sformatf("valid%0d", k), 32'(rvld[k]), 32'(idx >= 0));
      if (idx >= 0) begin
        last_data[k] = expq[idx].data;
        check($sformatf("coll%0d", k), 32'(coll[k]), 32'(expq[idx].coll));
`ifdef DUAL_PORT_RAM_PARITY_EN
        check($sformatf("perr%0d", k), 32'(perr[k]), 32'(expq[idx].perr));
`endif
      end else begin
        check($sformatf("coll%0d", k), 32'(coll[k]), 32'(0));
`ifdef DUAL_PORT_RAM_PARITY_EN
        check($sformatf("perr%0d", k), 32'(perr[k]), 32'(0));
`endif
      end
      check($sformatf("data%0d", k), 32'(rdata[k]), 32'(last_data[k]));
    end
    for (int i = expq.size() - 1; i >= 0; i--)
      if (expq[i].due <= edge_idx) expq.delete(i);
  endtask

  // One clock cycle: drive inputs, update the model, clock, check at negedge.
  task automatic cycle(input logic we, input logic [5:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [5:0] ra,
                       input logic inj);
    logic [15:0] oldw, neww;
    logic [1:0]  oldm, newm;
    logic        hit;
    exp_t        e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
`ifdef DUAL_PORT_RAM_PARITY_EN
    par_inj = inj;
`endif
    if (init_left == 0) begin
      if (re) begin
        hit  = we && (wa == ra);
        oldw = mdl_mem[ra];
        oldm = mdl_inj[ra];
        neww = oldw;
        newm = oldm;
        for (int b = 0; b < 2; b++) begin
          if (hit && be[b]) begin
            neww[b*8 +: 8] = wd[b*8 +: 8];
            newm[b] = inj;
          end
        end
        for (int k = 0; k < NI; k++) begin
          e.inst = k;
          e.due  = edge_idx + lat[k];   // accepting edge is edge_idx+1
          e.data = (hit && wf[k]) ? neww : oldw;
          e.perr = (hit && wf[k]) ? newm : oldm;
          e.coll = hit;
          expq.push_back(e);
        end
      end
      if (we) begin
        for (int b = 0; b < 2; b++) begin
          if (be[b]) begin
            mdl_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
            mdl_inj[wa][b] = inj;
          end
        end
      end
    end else begin
      init_left--;
    end
    @(posedge clk);
    edge_idx++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 16'h0, 2'b00, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    cycle(1'b1, a, d, be, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a);
    cycle(1'b0, 6'd0, 16'h0, 2'b00, 1'b1, a, 1'b0);
  endtask

  // Asynchronous reset pulse between clock edges, with reset-value checks.
  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
    par_inj = 1'b0;
`endif
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(rvld[k]), 32'(0));
      check($sformatf("rst_data%0d", k), 32'(rdata[k]), 32'(0));
      check($sformatf("rst_coll%0d", k), 32'(coll[k]), 32'(0));
      check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'(1));
      last_data[k] = '0;
    end
    expq.delete();
    for (int a = 0; a < DEPTH; a++) begin
      mdl_mem[a] = '0;
      mdl_inj[a] = '0;
    end
    init_left = DEPTH;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    edge_idx = 0;
    do_reset();

    // Fill phase with random port activity, which must be ignored.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'($urandom), 6'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 6'($urandom), 1'b0);

    // Top address reads back zero after the fill.
    rd(6'h3F);
    idle(4);

    // Byte-lane merge.
    wr(6'd1, 16'hB5D4, 2'b11);
    wr(6'd1, 16'h00A3, 2'b01);
    rd(6'd1);
    idle(4);

    // Back-to-back reads in order.
    wr(6'd0, 16'h1111, 2'b11);
    wr(6'd1, 16'h2222, 2'b11);
    wr(6'd2, 16'h3333, 2'b11);
    rd(6'd0);
    rd(6'd1);
    rd(6'd2);
    idle(4);

    // Same-address collision with a partial write, and a WR_BE=0 no-op.
    wr(6'd5, 16'hAAAA, 2'b11);
    cycle(1'b1, 6'd5, 16'h55CC, 2'b01, 1'b1, 6'd5, 1'b0);
    idle(4);
    cycle(1'b1, 6'd5, 16'hFFFF, 2'b00, 1'b1, 6'd5, 1'b0);
    idle(4);

`ifdef DUAL_PORT_RAM_PARITY_EN
    wr(6'd7, 16'h0034, 2'b01);
    cycle(1'b1, 6'd7, 16'h1234, 2'b10, 1'b0, 6'd0, 1'b1);
    rd(6'd7);
    idle(4);
`endif

    // Random traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom), 2'($urandom),
            1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
    idle(4);

    // Reset in the middle of the fill.
    do_reset();
    idle(20);
    do_reset();
    idle(DEPTH);

    // Reset with reads in flight; the array must come back zeroed.
    wr(6'd1, 16'hBEEF, 2'b11);
    rd(6'd1);
    rd(6'd2);
    do_reset();
    idle(DEPTH);
    rd(6'd1);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Simple dual-port RAM: one synchronous write port and one synchronous read port on one clock. Adds per-byte write enables, a parametrised read pipeline with a valid strobe, a selectable read-during-write collision policy, and a post-reset zero-fill sequencer. It is the parametrised successor of the single-port RAM, for buffers that need concurrent read and write.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of one write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH.
RD_LATENCY, 1, number of CLK edges from read request to RD_VALID; legal range 1..4.
WR_FIRST, 1, collision policy: 1 returns the new (merged) data, 0 returns the old data.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST  in  1  reset; asynchronous assert, active-low.
WR_EN  in  1  write request.
WR_ADDR  in  ADDR_WIDTH  write address.
WR_DATA  in  DATA_WIDTH  write data.
WR_BE  in  NUM_BYTES  byte enables; bit i covers WR_DATA[i*BYTE_WIDTH +: BYTE_WIDTH].
RD_EN  in  1  read request.
RD_ADDR  in  ADDR_WIDTH  read address.
RD_DATA  out  DATA_WIDTH  read data; valid when RD_VALID=1.
RD_VALID  out  1  one-cycle strobe per accepted read.
COLLISION  out  1  high with RD_VALID when that read hit a same-cycle write to the same address.
INIT_BUSY  out  1  high while the zero-fill runs; both ports are ignored while it is high.

Behaviour:
- Reset (RST=0, asynchronous): RD_DATA=0, RD_VALID=0, COLLISION=0, INIT_BUSY=1, fill counter=0, read pipeline flushed. Memory array is not cleared by reset itself.
- State INIT:
  - Each CLK edge writes 0 to mem[counter] and increments the counter.
  - After the write of address DEPTH-1, the block moves to READY.
  - INIT_BUSY falls on that same edge: it is high for exactly DEPTH edges after RST deasserts.
  - WR_EN and RD_EN are ignored and RD_VALID stays 0.
- State READY: remains there until the next reset.
- Write (READY): at the edge where WR_EN=1, each byte lane with WR_BE[i]=1 is updated; lanes with WR_BE[i]=0 are unchanged. WR_BE=0 with WR_EN=1 is a legal no-op.
- Read (READY):
  - A request is accepted at the edge where RD_EN=1. Back-to-back requests are accepted every cycle.
  - Data for a request accepted at edge N appears on RD_DATA with RD_VALID=1 after edge N+RD_LATENCY-1, i.e. it is visible in the cycle following that edge. With RD_LATENCY=1 it is visible in the cycle right after acceptance.
  - RD_VALID is high for exactly one cycle per request.
  - RD_DATA holds its last value while RD_VALID=0.
- Collision (WR_EN=1, RD_EN=1, WR_ADDR==RD_ADDR on the same edge):
  - WR_FIRST=1: returned word takes the new byte in enabled lanes and the old byte elsewhere.
  - WR_FIRST=0: returned word is the entire old content.
  - COLLISION=1 together with that read's RD_VALID, otherwise 0.
- Reads and writes to different addresses never interact.
- Reset mid-operation: in-flight reads are dropped with no RD_VALID, and INIT restarts from address 0, re-zeroing the whole array.
- Addresses are always in range (DEPTH = 2**ADDR_WIDTH); there is no wrap handling beyond the fill counter, which stops at DEPTH-1.

Optional Feature:
- Macro: DUAL_PORT_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written with the byte; INIT writes parity 0.
  - Extra input PAR_INJECT (1): when high during a write, the stored parity of the enabled lanes is inverted.
  - Extra output RD_PERR (NUM_BYTES): parity is recomputed on read; a lane's bit is high when it mismatches. RD_PERR is aligned with RD_VALID and is 0 otherwise, reset value 0.
- Undefined: no parity storage, and PAR_INJECT and RD_PERR are absent from the port list.

Test Plan (DATA_WIDTH=16, BYTE_WIDTH=8, ADDR_WIDTH=6, RD_LATENCY=2 unless noted):
- Release RST, then read addr 0x3F once INIT_BUSY=0 -> INIT_BUSY high for exactly 64 cycles; RD_DATA=0x0000 with one RD_VALID pulse 2 edges after the request.
- Write 0xB5D4 to addr 1 with WR_BE=2'b11, then write 0x00A3 with WR_BE=2'b01, then read addr 1 -> 0xB5A3.
- Reads of addr 0,1,2 on 3 consecutive cycles after writing 0x1111, 0x2222, 0x3333 -> RD_VALID high 3 consecutive cycles, data in order; with RD_LATENCY=1 each read appears one edge after request.
- Addr 5 holds 0xAAAA; same-cycle write 0x55CC (WR_BE=2'b01) and read of addr 5 -> WR_FIRST=1 returns 0xAACC with COLLISION=1; WR_FIRST=0 returns 0xAAAA with COLLISION=1.
- Assert RST mid-fill (counter≈20) and again with 2 reads in flight -> no RD_VALID for the dropped reads; INIT_BUSY high 64 cycles again; previously written addr 1 reads 0x0000.
- With DUAL_PORT_RAM_PARITY_EN: write 0x1234 to addr 7 with PAR_INJECT=1, WR_BE=2'b10, then read addr 7 -> RD_PERR=2'b10, RD_DATA=0x1234.
